// File: rtl/ex_div_unit_pkg.sv
// Shared cpu definitions for the EX-stage divider: op encodings, FSM states
// and the control-unit aluop to divide-op decode.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam logic [3:0] ALUOP_DIV  = 4'd10;
  localparam logic [3:0] ALUOP_DIVU = 4'd11;
  localparam logic [3:0] ALUOP_REM  = 4'd12;
  localparam logic [3:0] ALUOP_REMU = 4'd13;

  function automatic div_op_e aluop_to_div_op(input logic [3:0] aluop);
    div_op_e res;
    case (aluop)
      ALUOP_DIV:  res = OP_DIV;
      ALUOP_REM:  res = OP_REM;
      ALUOP_REMU: res = OP_REMU;
      default:    res = OP_DIVU;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_div_unit_div_core.sv
// Unsigned radix-2 restoring divider datapath: quotient/dividend shift
// register Q, partial remainder R, divisor D and iteration counter.
module div_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] d_in,
  output logic [XLEN-1:0] q_next,
  output logic [XLEN-1:0] r_next,
  output logic            done
);

  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] d_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   r_shift;
  logic            ge;

  // R is kept XLEN wide: after every step it is below D, so its top bit of
  // the 33-bit partial remainder is always zero and only lives in r_shift.
  always_comb begin
    r_shift = {r_q, q_q[XLEN-1]};
    ge      = (r_shift >= {1'b0, d_q});
    r_next  = ge ? (r_shift[XLEN-1:0] - d_q) : r_shift[XLEN-1:0];
    q_next  = {q_q[XLEN-2:0], ge};
    done    = step && (cnt_q == CW'(ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      q_q   <= q_in;
      d_q   <= d_in;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (step) begin
      q_q   <= q_next;
      r_q   <= r_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage: stalls ID/EX while
// computing and emits one registered, rd-tagged result pulse.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      dest_addr_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic [4:0]      dest_addr_out
);

  div_state_e      state_q, state_d;
  logic            accept, step, core_done;
  logic            signed_op, is_rem, sign_a, sign_b;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic [XLEN-1:0] q_next, r_next, q_fix, r_fix;
  logic            is_rem_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      dest_q;

  always_comb begin
    signed_op   = (op == OP_DIV) || (op == OP_REM);
    is_rem      = (op == OP_REM) || (op == OP_REMU);
    sign_a      = signed_op && dividend[XLEN-1];
    sign_b      = signed_op && divisor[XLEN-1];
    a_abs       = sign_a ? (-dividend) : dividend;
    b_abs       = sign_b ? (-divisor) : divisor;
    div_zero    = (divisor == '0);
    overflow    = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special     = div_zero || overflow;
    if (div_zero) special_res = is_rem ? dividend : '1;
    else          special_res = is_rem ? '0 : dividend;
    q_fix       = neg_q_q ? (-q_next) : q_next;
    r_fix       = neg_r_q ? (-r_next) : r_next;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    step         = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush && !rst) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = special ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (core_done) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = !flush && !rst;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      dest_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dest_q   <= dest_addr_in;
        is_rem_q <= is_rem;
        neg_q_q  <= sign_a ^ sign_b;
        neg_r_q  <= sign_a;
        if (special) result_q <= special_res;
      end
      // Final step: sign-fix the core's next values so result is ready in DONE.
      if (step && core_done) result_q <= is_rem_q ? r_fix : q_fix;
    end
  end

  div_core #(
    .XLEN  (XLEN),
    .ITERS (ITERS)
  ) u_div_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .q_in   (a_abs),
    .d_in   (b_abs),
    .q_next (q_next),
    .r_next (r_next),
    .done   (core_done)
  );

  assign busy          = (state_q != ST_IDLE);
  assign result        = result_q;
  assign dest_addr_out = dest_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;
  logic [4:0]  dest_addr_in, dest_addr_out;
  logic        stall, busy, result_valid;

  int checks = 0;
  int failures = 0;

  ex_div_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .dividend      (dividend),
    .divisor       (divisor),
    .dest_addr_in  (dest_addr_in),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .result        (result),
    .result_valid  (result_valid),
    .dest_addr_out (dest_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                        input string name);
    int c, lat, stalls;
    logic got;
    logic [31:0] res;
    logic [4:0] tag;
    @(posedge clk); #1;
    op = o; dividend = a; divisor = b; dest_addr_in = rd; start = 1'b1;
    got = 1'b0; c = 0; stalls = 0; lat = -1; res = '0; tag = '0;
    while (!got && c < 60) begin
      #1;
      if (stall) stalls++;
      if (result_valid) begin
        got = 1'b1; lat = c; res = result; tag = dest_addr_out;
      end
      if (!stall) start = 1'b0;
      if (!got) begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: no result_valid within 60 cycles", name);
    end else begin
      checks++;
      if (lat !== exp_lat) begin
        failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
      end
      checks++;
      if (stalls !== exp_lat) begin
        failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_lat);
      end
      checks++;
      if (res !== exp) begin
        failures++; $display("FAIL %s result got=%h exp=%h", name, res, exp);
      end
      checks++;
      if (tag !== rd) begin
        failures++; $display("FAIL %s dest_addr got=%0d exp=%0d", name, tag, rd);
      end
    end
    @(posedge clk); #2;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      failures++;
      $display("FAIL %s after_done valid=%b busy=%b result=%h exp valid=0 busy=0 result=%h",
               name, result_valid, busy, result, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0; dest_addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({stall, busy, result_valid} !== 3'b000 || result !== 32'h0 || dest_addr_out !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs stall=%b busy=%b valid=%b result=%h rd=%0d exp all 0",
               stall, busy, result_valid, result, dest_addr_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33, "remu_100_7");
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 5'd31, 32'hFFFFFFFF, 33, "divu_max_1");
  endtask

  task automatic test_signed();
    run_op(OP_DIV, 32'hFFFFFF9C, 32'd7, 5'd5, 32'hFFFFFFF2, 33, "div_m100_7");
    run_op(OP_REM, 32'hFFFFFF9C, 32'd7, 5'd6, 32'hFFFFFFFE, 33, "rem_m100_7");
    run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, 5'd9, 32'hFFFFFFF2, 33, "div_100_m7");
    run_op(OP_REM, 32'd100, 32'hFFFFFFF9, 5'd10, 32'd2, 33, "rem_100_m7");
  endtask

  task automatic test_div_by_zero();
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, 1, "divu_5_0");
    run_op(OP_REMU, 32'd5, 32'd0, 5'd12, 32'd5, 1, "remu_5_0");
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 5'd13, 32'hFFFFFFFF, 1, "div_m7_0");
    run_op(OP_REM, 32'hFFFFFFF9, 32'd0, 5'd14, 32'hFFFFFFF9, 1, "rem_m7_0");
  endtask

  task automatic test_overflow();
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, "div_ovf");
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1, "rem_ovf");
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int pulses;
    prev = result;
    @(posedge clk); #1;
    op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; dest_addr_in = 5'd20; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL flush_in_run stall=%b busy=%b exp 1 1", stall, busy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_next stall=%b busy=%b valid=%b exp 0 0 0", stall, busy, result_valid);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || result !== prev) begin
      failures++;
      $display("FAIL flush_no_result pulses=%0d result=%h exp pulses=0 result=%h", pulses, result, prev);
    end
  endtask

  task automatic test_rst_mid();
    int pulses;
    @(posedge clk); #1;
    op = OP_DIV; dividend = 32'hFFFFFF9C; divisor = 32'd7; dest_addr_in = 5'd21; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, busy, result_valid} !== 3'b000 || result !== 32'h0 || dest_addr_out !== 5'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs stall=%b busy=%b valid=%b result=%h rd=%0d exp all 0",
               stall, busy, result_valid, result, dest_addr_out);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL rst_mid_no_result pulses=%0d exp 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, c1, c2;
    logic [31:0] r1, r2;
    logic [4:0] t1, t2;
    pulses = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0; t1 = '0; t2 = '0;
    @(posedge clk); #1;
    op = OP_DIVU; dividend = 32'd20; divisor = 32'd3; dest_addr_in = 5'd7; start = 1'b1;
    for (int c = 0; c < 110; c++) begin
      #1;
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin
          c1 = c; r1 = result; t1 = dest_addr_out;
          dividend = 32'd9; divisor = 32'd4; dest_addr_in = 5'd8;
        end else if (pulses == 2) begin
          c2 = c; r2 = result; t2 = dest_addr_out;
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (pulses !== 2) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses);
    end
    checks++;
    if (c1 !== 33 || (c2 - c1) !== 34) begin
      failures++; $display("FAIL b2b_timing first=%0d gap=%0d exp first=33 gap=34", c1, c2 - c1);
    end
    checks++;
    if (r1 !== 32'd6 || t1 !== 5'd7) begin
      failures++; $display("FAIL b2b_first result=%h rd=%0d exp result=6 rd=7", r1, t1);
    end
    checks++;
    if (r2 !== 32'd2 || t2 !== 5'd8) begin
      failures++; $display("FAIL b2b_second result=%h rd=%0d exp result=2 rd=8", r2, t2);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative RV32M divide/remainder unit for the EX stage. It consumes the operands, divide op and destination register held in the ID/EX pipeline register and freezes that register with a stall request while it computes. It produces one 32-bit result, tagged with the destination register, for the EX/MEM register. It implements DIV, DIVU, REM and REMU with the RISC-V divide-by-zero and overflow rules.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, XLEN, number of radix-2 iterations.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX-stage instruction is a divide op; level, held while stall is high.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value from ID/EX (already forwarded).
- divisor  in  32  rs2 value from ID/EX (already forwarded).
- dest_addr_in  in  5  rd from ID/EX.
- flush  in  1  kill the in-flight operation (branch/jump redirect).
- stall  out  1  hold ID/EX and earlier stages.
- busy  out  1  state is not IDLE.
- result  out  32  quotient or remainder; valid only with result_valid.
- result_valid  out  1  one-cycle pulse, result ready for EX/MEM.
- dest_addr_out  out  5  rd captured at start.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 and flush=0 captures op, dest_addr_in and the operand signs.
  - For DIV/REM the absolute values are loaded into the 32-bit quotient register Q and divisor register D, and the 33-bit partial remainder R is cleared.
  - For DIVU/REMU the operands are loaded as-is.
  - Special cases go straight to DONE with the result preloaded:
    - divisor==0: quotient 0xFFFFFFFF, remainder = dividend.
    - signed ops with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - All other cases go to RUN with iteration counter cnt=0.
- RUN, one restoring step per cycle:
  - R' = {R[31:0], Q[31]}.
  - If R' >= {1'b0, D}, then R = R' - D and Q = {Q[30:0], 1}; otherwise R = R' and Q = {Q[30:0], 0}.
  - cnt increments; after the step with cnt==ITERS-1, go to DONE.
- DONE:
  - Sign fix-up: the quotient is negated when sign(dividend) xor sign(divisor) for DIV; the remainder is negated when sign(dividend) for REM.
  - result is driven and result_valid=1.
  - The next state is always IDLE. start is ignored in DONE, because ID/EX advances on this edge.
- flush has priority over start and over every state: next state IDLE, no result_valid. flush in DONE suppresses result_valid in that cycle.
- stall = (IDLE & start & ~flush) | RUN. It is combinational and is low in DONE.
- rst mid-operation behaves like flush. On reset, all outputs are 0, state is IDLE, and Q, R, D and cnt are 0.

## Timing
- A start sampled at edge N gives a normal result_valid in cycle N+33 (32 RUN cycles plus DONE), and a special-case result_valid in cycle N+1.
- stall is high from the start cycle through the last RUN cycle: 33 cycles normally, 1 cycle for special cases.
- Back-to-back divides: the second start is seen in IDLE in the cycle after DONE, so there is no lost or duplicated op.
- result and dest_addr_out are registered. They hold their last value outside DONE, and consumers qualify them with result_valid.

## Structure
- The shared cpu package holds the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), the state enum, and the aluop-to-op decode constant mapping used by the control unit.
- There is one natural sub-module, div_core. It is the unsigned iterative restoring datapath with Q, R, D and cnt, controlled by load/step/done. ex_div_unit wraps it with the FSM, sign handling, special cases and stall logic.

## Test plan
- DIVU 100 / 7: stall high for 33 cycles, result_valid in cycle N+33, result 14, dest_addr_out matches rd. REMU gives 2.
- DIV -100 / 7 gives 0xFFFFFFF2 (-14); REM -100 / 7 gives 0xFFFFFFFE (-2); DIV 100 / -7 gives -14.
- DIVU 5 / 0 gives 0xFFFFFFFF and REMU 5 / 0 gives 5, both with result_valid in cycle N+1 and a single stall cycle.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000, and REM of the same operands gives 0, in cycle N+1.
- flush asserted in RUN cycle 10: next cycle IDLE, stall=0, busy=0, and no result_valid ever for that op. rst asserted mid-RUN behaves the same way and all outputs read 0.
- Two consecutive DIVU ops (20/3, then 9/4): results 6 and 2, exactly two result_valid pulses 34 cycles apart, with correct rd tags.
